mc_table_loader: RTL and testbench

- Writer/initiator side of the MC pricing core's table interface.
- Accepts a stream of 17-bit table words (exp-sigma table, then exp-mu table) and writes them into the core's inactive RAM bank.
- Flips the bank switch, pulses start, and captures the core's price on done.
- Loading of batch k+1 overlaps execution of batch k (double buffering).

---
 rtl/mc_table_if.sv | 47 ++++
 rtl/mc_table_loader.sv | 182 ++++++++++++++++++
 tb/tb_mc_table_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_table_if.sv
// Table-stream, core-control and result bus between mc_table_loader and its neighbours.
// oTimeout is present only when MC_LOADER_TIMEOUT_EN is defined.
interface mc_table_if #(
    parameter int unsigned pathWidth = 6,
    parameter int unsigned logT      = 6
);
    logic [16:0]           iData;
    logic                  iValid;
    logic                  oReady;
    logic [pathWidth-1:0]  oSigmaWriteAddress;
    logic [16:0]           oSigmaWriteData;
    logic                  oSigmaWE;
    logic [logT-1:0]       oMuWriteAddress;
    logic [16:0]           oMuWriteData;
    logic                  oMuWE;
    logic                  oSwitch;
    logic                  oStart;
    logic [17+logT-1:0]    iPrice;
    logic                  iDone;
    logic [17+logT-1:0]    oResult;
    logic                  oResultValid;
    logic                  iResultReady;
    logic                  oBusy;
`ifdef MC_LOADER_TIMEOUT_EN
    logic                  oTimeout;
`endif

    modport master (
        input  iData, iValid, iPrice, iDone, iResultReady,
        output oReady, oSigmaWriteAddress, oSigmaWriteData, oSigmaWE,
               oMuWriteAddress, oMuWriteData, oMuWE, oSwitch, oStart,
               oResult, oResultValid, oBusy
`ifdef MC_LOADER_TIMEOUT_EN
        , output oTimeout
`endif
    );

    modport slave (
        output iData, iValid, iPrice, iDone, iResultReady,
        input  oReady, oSigmaWriteAddress, oSigmaWriteData, oSigmaWE,
               oMuWriteAddress, oMuWriteData, oMuWE, oSwitch, oStart,
               oResult, oResultValid, oBusy
`ifdef MC_LOADER_TIMEOUT_EN
        , input oTimeout
`endif
    );
endinterface

// File: rtl/mc_table_loader.sv
// Double-buffered table loader for the MC pricing core: fills the idle bank, swaps, starts, captures price.
// Optional MC_LOADER_TIMEOUT_EN adds a busy watchdog with sticky oTimeout.
module mc_table_loader #(
    parameter int unsigned T         = 64,
    parameter int unsigned logT      = 6,
    parameter int unsigned pathWidth = 6
`ifdef MC_LOADER_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 4096
`endif
) (
    input  logic          CLK,
    input  logic          iRST_N,
    mc_table_if.master    bus
);
    localparam int unsigned DW = 17;
    localparam int unsigned PW = DW + logT;
    localparam logic [pathWidth-1:0] SIG_LAST = '1;
    localparam logic [logT-1:0]      MU_LAST  = logT'(T - 1);
`ifdef MC_LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {LOAD_SIGMA, LOAD_MU, WAIT_CORE, SWAP, START} state_e;

    state_e               state_q, state_d;
    logic [pathWidth-1:0] sig_cnt_q, sig_cnt_d, sig_addr_q, sig_addr_d;
    logic [logT-1:0]      mu_cnt_q, mu_cnt_d, mu_addr_q, mu_addr_d;
    logic [DW-1:0]        sig_data_q, sig_data_d, mu_data_q, mu_data_d;
    logic                 sig_we_q, sig_we_d, mu_we_q, mu_we_d;
    logic                 ready_q, ready_d, switch_q, switch_d, start_q, start_d;
    logic                 busy_q, busy_d, result_valid_q, result_valid_d;
    logic [PW-1:0]        result_q, result_d;
    logic                 accept_c;
`ifdef MC_LOADER_TIMEOUT_EN
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    assign accept_c = bus.iValid & ready_q;

    // Next-state: table fill, bank swap/start sequencing, and result capture/drain.
    always_comb begin
        state_d        = state_q;
        sig_cnt_d      = sig_cnt_q;
        mu_cnt_d       = mu_cnt_q;
        sig_we_d       = 1'b0;
        sig_addr_d     = sig_addr_q;
        sig_data_d     = sig_data_q;
        mu_we_d        = 1'b0;
        mu_addr_d      = mu_addr_q;
        mu_data_d      = mu_data_q;
        switch_d       = switch_q;
        start_d        = 1'b0;
        busy_d         = busy_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
`ifdef MC_LOADER_TIMEOUT_EN
        to_cnt_d       = to_cnt_q;
        timeout_d      = timeout_q;
`endif

        case (state_q)
            LOAD_SIGMA: if (accept_c) begin
                sig_we_d   = 1'b1;
                sig_addr_d = sig_cnt_q;
                sig_data_d = bus.iData;
                if (sig_cnt_q == SIG_LAST) begin
                    sig_cnt_d = '0;
                    state_d   = LOAD_MU;
                end else begin
                    sig_cnt_d = sig_cnt_q + pathWidth'(1);
                end
            end
            LOAD_MU: if (accept_c) begin
                mu_we_d   = 1'b1;
                mu_addr_d = mu_cnt_q;
                mu_data_d = bus.iData;
                if (mu_cnt_q == MU_LAST) begin
                    mu_cnt_d = '0;
                    state_d  = WAIT_CORE;
                end else begin
                    mu_cnt_d = mu_cnt_q + logT'(1);
                end
            end
            // The filled bank may only go live once the previous price is out of the way.
            WAIT_CORE: if (!busy_q && !result_valid_q) state_d = SWAP;
            SWAP: begin
                switch_d = ~switch_q;
                start_d  = 1'b1;
                busy_d   = 1'b1;
                state_d  = START;
`ifdef MC_LOADER_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            START:   state_d = LOAD_SIGMA;
            default: state_d = LOAD_SIGMA;
        endcase

`ifdef MC_LOADER_TIMEOUT_EN
        if (busy_q) begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_q == TO_LAST && !bus.iDone) begin
                busy_d    = 1'b0;
                timeout_d = 1'b1;
            end
        end
`endif

        // A capture takes priority over a drain in the same cycle.
        if (busy_q && bus.iDone) begin
            result_d       = bus.iPrice;
            result_valid_d = 1'b1;
            busy_d         = 1'b0;
        end else if (result_valid_q && bus.iResultReady) begin
            result_valid_d = 1'b0;
        end

        ready_d = (state_d == LOAD_SIGMA) || (state_d == LOAD_MU);
    end

    always_ff @(posedge CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q        <= LOAD_SIGMA;
            sig_cnt_q      <= '0;
            mu_cnt_q       <= '0;
            sig_we_q       <= 1'b0;
            sig_addr_q     <= '0;
            sig_data_q     <= '0;
            mu_we_q        <= 1'b0;
            mu_addr_q      <= '0;
            mu_data_q      <= '0;
            ready_q        <= 1'b0;
            switch_q       <= 1'b0;
            start_q        <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
`ifdef MC_LOADER_TIMEOUT_EN
            to_cnt_q       <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            sig_cnt_q      <= sig_cnt_d;
            mu_cnt_q       <= mu_cnt_d;
            sig_we_q       <= sig_we_d;
            sig_addr_q     <= sig_addr_d;
            sig_data_q     <= sig_data_d;
            mu_we_q        <= mu_we_d;
            mu_addr_q      <= mu_addr_d;
            mu_data_q      <= mu_data_d;
            ready_q        <= ready_d;
            switch_q       <= switch_d;
            start_q        <= start_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
`ifdef MC_LOADER_TIMEOUT_EN
            to_cnt_q       <= to_cnt_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    assign bus.oReady             = ready_q;
    assign bus.oSigmaWriteAddress = sig_addr_q;
    assign bus.oSigmaWriteData    = sig_data_q;
    assign bus.oSigmaWE           = sig_we_q;
    assign bus.oMuWriteAddress    = mu_addr_q;
    assign bus.oMuWriteData       = mu_data_q;
    assign bus.oMuWE              = mu_we_q;
    assign bus.oSwitch            = switch_q;
    assign bus.oStart             = start_q;
    assign bus.oResult            = result_q;
    assign bus.oResultValid       = result_valid_q;
    assign bus.oBusy              = busy_q;
`ifdef MC_LOADER_TIMEOUT_EN
    assign bus.oTimeout           = timeout_q;
`endif
endmodule

// File: tb/tb_mc_table_loader.sv
// Randomised bench for mc_table_loader: word-index reference model checked every cycle plus literal pins.
// Covers the MC_LOADER_TIMEOUT_EN watchdog when that macro is defined.
module tb_mc_table_loader;
    localparam int SIG_N = 64;
    localparam int WORDS = 128;
`ifdef MC_LOADER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 512;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_table_if #(.pathWidth(6), .logT(6)) bus();

`ifdef MC_LOADER_TIMEOUT_EN
    mc_table_loader #(.T(64), .logT(6), .pathWidth(6), .TIMEOUT(TB_TIMEOUT)) dut (
        .CLK(clk), .iRST_N(rst_n), .bus(bus));
`else
    mc_table_loader #(.T(64), .logT(6), .pathWidth(6)) dut (
        .CLK(clk), .iRST_N(rst_n), .bus(bus));
`endif

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: a batch is a 128-word sequence; word k lands at sigma[k] or mu[k-64].
    int          m_idx, m_launch, m_tcnt;
    logic        e_ready, e_swe, e_mwe, e_switch, e_start, e_busy, e_rv, e_to;
    logic [5:0]  e_saddr, e_maddr;
    logic [16:0] e_sdata, e_mdata;
    logic [22:0] e_result;

    task automatic model_reset();
        m_idx = 0; m_launch = 0; m_tcnt = 0;
        e_ready = 0; e_swe = 0; e_mwe = 0; e_switch = 0; e_start = 0; e_busy = 0; e_rv = 0; e_to = 0;
        e_saddr = 0; e_maddr = 0; e_sdata = 0; e_mdata = 0; e_result = 0;
    endtask

    task automatic model_step();
        logic acc, busy_o, rv_o;
        acc = bus.iValid && e_ready;
        busy_o = e_busy;
        rv_o = e_rv;
        e_swe = 0; e_mwe = 0; e_start = 0;
        if (acc) begin
            if (m_idx < SIG_N) begin e_swe = 1; e_saddr = 6'(m_idx); e_sdata = bus.iData; end
            else begin e_mwe = 1; e_maddr = 6'(m_idx - SIG_N); e_mdata = bus.iData; end
            m_idx++;
        end else if (m_launch == 2) begin
            m_launch = 0; m_idx = 0;
        end else if (m_launch == 1) begin
            m_launch = 2; e_switch = !e_switch; e_start = 1; e_busy = 1; m_tcnt = 0;
        end else if (m_idx == WORDS && !busy_o && !rv_o) begin
            m_launch = 1;
        end
`ifdef MC_LOADER_TIMEOUT_EN
        if (busy_o && !bus.iDone) begin
            m_tcnt++;
            if (m_tcnt == TB_TIMEOUT) begin e_busy = 0; e_to = 1; end
        end
`endif
        if (busy_o && bus.iDone) begin e_result = bus.iPrice; e_rv = 1; e_busy = 0; end
        else if (rv_o && bus.iResultReady) e_rv = 0;
        e_ready = (m_idx < WORDS);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("oReady", 32'(bus.oReady), 32'(e_ready));
            check("oSigmaWE", 32'(bus.oSigmaWE), 32'(e_swe));
            check("oSigmaWriteAddress", 32'(bus.oSigmaWriteAddress), 32'(e_saddr));
            check("oSigmaWriteData", 32'(bus.oSigmaWriteData), 32'(e_sdata));
            check("oMuWE", 32'(bus.oMuWE), 32'(e_mwe));
            check("oMuWriteAddress", 32'(bus.oMuWriteAddress), 32'(e_maddr));
            check("oMuWriteData", 32'(bus.oMuWriteData), 32'(e_mdata));
            check("oSwitch", 32'(bus.oSwitch), 32'(e_switch));
            check("oStart", 32'(bus.oStart), 32'(e_start));
            check("oBusy", 32'(bus.oBusy), 32'(e_busy));
            check("oResult", 32'(bus.oResult), 32'(e_result));
            check("oResultValid", 32'(bus.oResultValid), 32'(e_rv));
`ifdef MC_LOADER_TIMEOUT_EN
            check("oTimeout", 32'(bus.oTimeout), 32'(e_to));
`endif
        end
    end

    task automatic rnd_core();
        bus.iDone        = ($urandom_range(0, 5) == 0);
        bus.iPrice       = 23'($urandom);
        bus.iResultReady = 1'($urandom_range(0, 1));
    endtask

    // mode 0: iValid always 1, mode 1: toggles 1,0,1,0..., mode 2: random.
    task automatic stream(input int n, input int mode, input bit seq, input bit rnd);
        int i = 0;
        int guard = 0;
        logic v;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            case (mode)
                0:       v = 1'b1;
                1:       v = ((guard % 2) == 1);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.iValid = v;
            bus.iData  = seq ? 17'(i) : 17'($urandom);
            if (rnd) rnd_core();
            if (v && bus.oReady) i++;
        end
        if (i < n) check("stream_stall", 32'(i), 32'(n));
        @(negedge clk);
        bus.iValid = 1'b0;
        if (rnd) rnd_core();
    endtask

    task automatic wait_start(input int budget, input bit rnd, output int n);
        n = 0;
        while (!bus.oStart && n < budget) begin
            @(negedge clk);
            n++;
            if (rnd && !bus.oStart) rnd_core();
        end
        if (!bus.oStart) check("wait_start_timeout", 32'(0), 32'(1));
    endtask

    task automatic pulse_ready();
        @(negedge clk); bus.iResultReady = 1'b1;
        @(negedge clk); bus.iResultReady = 1'b0;
    endtask

    initial begin
        int n;
        bus.iData = '0; bus.iValid = 1'b0; bus.iPrice = '0; bus.iDone = 1'b0; bus.iResultReady = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_oReady", 32'(bus.oReady), 32'(0));
        rst_n = 1'b1;

        // Batch 1: data = word index.
        stream(WORDS, 0, 1'b1, 1'b0);
        check("b1_last_mu_we", 32'(bus.oMuWE), 32'(1));
        check("b1_last_mu_addr", 32'(bus.oMuWriteAddress), 32'(63));
        check("b1_last_mu_data", 32'(bus.oMuWriteData), 32'(127));
        wait_start(50, 1'b0, n);
        check("b1_start_gap", 32'(n), 32'(2));
        check("b1_switch", 32'(bus.oSwitch), 32'(1));

        // Batch 2 loads while run 1 is busy, then waits for capture and drain.
        stream(WORDS, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("b2_hold_ready", 32'(bus.oReady), 32'(0));
        check("b2_hold_switch", 32'(bus.oSwitch), 32'(1));
        bus.iDone = 1'b1; bus.iPrice = 23'h012345;
        @(negedge clk); bus.iDone = 1'b0;
        check("b2_result", 32'(bus.oResult), 32'h012345);
        check("b2_result_valid", 32'(bus.oResultValid), 32'(1));
        repeat (4) @(negedge clk);
        check("b2_switch_unread", 32'(bus.oSwitch), 32'(1));
        pulse_ready();
        wait_start(50, 1'b0, n);
        check("b2_switch_after_drain", 32'(bus.oSwitch), 32'(0));

        // Batch 3: toggling iValid in sigma, random in mu, then a held iDone.
        stream(SIG_N, 1, 1'b1, 1'b0);
        check("b3_sigma_last_addr", 32'(bus.oSigmaWriteAddress), 32'(63));
        stream(WORDS - SIG_N, 2, 1'b0, 1'b0);
        @(negedge clk); bus.iDone = 1'b1; bus.iPrice = 23'd5;
        @(negedge clk); bus.iPrice = 23'd6;
        @(negedge clk); bus.iPrice = 23'd7;
        @(negedge clk); bus.iDone = 1'b0;
        check("held_done_result", 32'(bus.oResult), 32'(5));
        check("held_done_busy", 32'(bus.oBusy), 32'(0));
        pulse_ready();
        wait_start(50, 1'b0, n);

        // Random batches with random done/drain traffic.
        for (int b = 0; b < 4; b++) begin
            stream(WORDS, 2, 1'b0, 1'b1);
            wait_start(500, 1'b1, n);
        end
        bus.iDone = 1'b0; bus.iResultReady = 1'b0;

        // Asynchronous reset part-way through the sigma table.
        stream(40, 0, 1'b0, 1'b0);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(bus.oReady), 32'(0));
        check("arst_we", 32'({bus.oSigmaWE, bus.oMuWE}), 32'(0));
        check("arst_addr", 32'({bus.oSigmaWriteAddress, bus.oMuWriteAddress}), 32'(0));
        check("arst_data", 32'(bus.oSigmaWriteData | bus.oMuWriteData), 32'(0));
        check("arst_ctrl", 32'({bus.oSwitch, bus.oStart, bus.oBusy, bus.oResultValid}), 32'(0));
        check("arst_result", 32'(bus.oResult), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stream(1, 0, 1'b0, 1'b0);
        check("post_rst_first_addr", 32'(bus.oSigmaWriteAddress), 32'(0));
        check("post_rst_first_we", 32'(bus.oSigmaWE), 32'(1));
        stream(WORDS - 1, 2, 1'b0, 1'b0);
        wait_start(50, 1'b0, n);
        check("post_rst_switch", 32'(bus.oSwitch), 32'(1));

`ifdef MC_LOADER_TIMEOUT_EN
        // Run never completes: watchdog drops oBusy and latches oTimeout.
        n = 0;
        while (bus.oBusy && n < TB_TIMEOUT + 50) begin @(negedge clk); n++; end
        check("timeout_cycles", 32'(n), 32'(TB_TIMEOUT));
        check("timeout_flag", 32'(bus.oTimeout), 32'(1));
        check("timeout_no_result", 32'(bus.oResultValid), 32'(0));
`else
        repeat (5) @(negedge clk);
        bus.iDone = 1'b1; bus.iPrice = 23'h7abcde;
        @(negedge clk); bus.iDone = 1'b0;
        check("final_result", 32'(bus.oResult), 32'h7abcde);
        pulse_ready();
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
